// File: rtl/sat_counter_bp.sv
// sat_counter_bp: table of saturating counters for branch direction
// prediction, with hit/miss statistics.
//
// Each resolved branch reads its table entry and registers a prediction
// (the entry's MSB) and a miss flag. The entry is trained towards the
// outcome on that same edge. Results appear one cycle after the branch.
//
// Build option: define SAT_COUNTER_BP_GSHARE_EN to index the table with
// branch_id XOR the zero-extended global history register (gshare).
// Without it the table is indexed by branch_id alone. The history
// register is still kept, but it does not affect any output.
//
// Counter entries are stored XOR-ed with the weakly-not-taken value. An
// all-zero register therefore decodes to the reset state, so the table
// also comes up correctly from zero-initialised flops at time zero.
module sat_counter_bp #(
  parameter int IDX_W  = 3,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [IDX_W-1:0] branch_id,
  input  logic             outcome,
  output logic             out_valid,
  output logic             pred,
  output logic             miss,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int DEPTH = 1 << IDX_W;

  // Weakly-not-taken: the largest value whose MSB is still 0.
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Table index and read-side prediction.
  logic [IDX_W-1:0]  idx;
  logic [DEPTH-1:0]  msb_vec;
  logic              cur_pred;
  logic              cur_miss;

  // Global history.
  logic [HIST_W-1:0] ghr_reg;
  logic [HIST_W-1:0] ghr_next;

  // Statistics.
  logic [CNT_W-1:0]  hit_count_reg;
  logic [CNT_W-1:0]  hit_count_next;
  logic [CNT_W-1:0]  miss_count_reg;
  logic [CNT_W-1:0]  miss_count_next;

  // Registered result.
  logic              out_valid_reg;
  logic              pred_reg;
  logic              miss_reg;

`ifdef SAT_COUNTER_BP_GSHARE_EN
  // gshare: fold the global history into the low index bits.
  always_comb begin
    idx = branch_id ^ IDX_W'(ghr_reg);
  end
`else
  // Plain bimodal indexing: the history is tracked but never steers the table.
  always_comb begin
    idx = branch_id;
  end

  logic unused_ghr;
  assign unused_ghr = ^ghr_reg;
`endif

  // One saturating counter per table entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [CTR_W-1:0] enc_reg;
    logic [CTR_W-1:0] ctr_val;
    logic [CTR_W-1:0] ctr_next;
    logic             hit_sel;

    assign ctr_val     = enc_reg ^ CTR_WNT;
    assign msb_vec[gi] = ctr_val[CTR_W-1];
    assign hit_sel     = valid && (idx == IDX_W'(gi));

    // Move one step towards the outcome, sticking at both ends.
    always_comb begin
      ctr_next = ctr_val;
      if (outcome) begin
        if (ctr_val != CTR_MAX) begin
          ctr_next = ctr_val + CTR_W'(1);
        end
      end else begin
        if (ctr_val != '0) begin
          ctr_next = ctr_val - CTR_W'(1);
        end
      end
    end

    // Entry update; reset returns the entry to weakly-not-taken.
    always_ff @(posedge clk) begin
      if (reset) begin
        enc_reg <= '0;
      end else if (hit_sel) begin
        enc_reg <= ctr_next ^ CTR_WNT;
      end
    end
  end

  // The read sees the pre-update value of this edge. The write lands on the
  // same edge, so a back-to-back access to the same entry reads fresh data.
  always_comb begin
    cur_pred = msb_vec[idx];
    cur_miss = cur_pred ^ outcome;
  end

  // Shift each resolved outcome into the history LSB.
  always_comb begin
    ghr_next = (ghr_reg << 1) | HIST_W'(outcome);
  end

  // History register; only resolved branches advance it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_reg <= '0;
    end else if (valid) begin
      ghr_reg <= ghr_next;
    end
  end

  // Saturating hit/miss accounting for the branch presented this cycle.
  always_comb begin
    hit_count_next  = hit_count_reg;
    miss_count_next = miss_count_reg;
    if (valid) begin
      if (cur_miss) begin
        if (miss_count_reg != CNT_MAX) begin
          miss_count_next = miss_count_reg + CNT_W'(1);
        end
      end else begin
        if (hit_count_reg != CNT_MAX) begin
          hit_count_next = hit_count_reg + CNT_W'(1);
        end
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      hit_count_reg  <= hit_count_next;
      miss_count_reg <= miss_count_next;
    end
  end

  // Result register: one-cycle latency, and zero on idle or reset cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      pred_reg      <= 1'b0;
      miss_reg      <= 1'b0;
    end else begin
      out_valid_reg <= valid;
      pred_reg      <= valid & cur_pred;
      miss_reg      <= valid & cur_miss;
    end
  end

  assign out_valid  = out_valid_reg;
  assign pred       = pred_reg;
  assign miss       = miss_reg;
  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_sat_counter_bp.sv
// Scoreboard bench for sat_counter_bp. It drives a default instance and a
// CNT_W=4 instance with the same stimulus. A table-of-integers model
// produces one expectation per cycle, and a monitor compares it with both
// instances.
module tb_sat_counter_bp;

  localparam int IDX_W  = 3;
  localparam int CTR_W  = 2;
  localparam int HIST_W = 3;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int CMAX   = (1 << CTR_W) - 1;
  localparam int THR    = 1 << (CTR_W - 1);
  localparam int WNT    = THR - 1;
  localparam int CAP16  = 65535;
  localparam int CAP4   = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             valid = 1'b0;
  logic [IDX_W-1:0] branch_id = '0;
  logic             outcome = 1'b0;

  logic             out_valid, pred, miss;
  logic [15:0]      hit_count, miss_count;
  logic             out_valid4, pred4, miss4;
  logic [3:0]       hit_count4, miss_count4;

  sat_counter_bp #(.IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .branch_id(branch_id), .outcome(outcome),
    .out_valid(out_valid), .pred(pred), .miss(miss),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  sat_counter_bp #(.IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .valid(valid), .branch_id(branch_id), .outcome(outcome),
    .out_valid(out_valid4), .pred(pred4), .miss(miss4),
    .hit_count(hit_count4), .miss_count(miss_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ov;
    bit p;
    bit m;
    int hits;
    int misses;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Reference state: plain integers per table entry.
  int tbl [DEPTH];
  int ghr;
  int hits;
  int misses;

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    foreach (tbl[i]) tbl[i] = WNT;
    ghr    = 0;
    hits   = 0;
    misses = 0;
  endfunction

  function automatic exp_t model_branch(int id, bit t);
    exp_t e;
    int   i;
    i = id;
`ifdef SAT_COUNTER_BP_GSHARE_EN
    i = id ^ ghr;
`endif
    e.ov = 1'b1;
    e.p  = (tbl[i] >= THR);
    e.m  = (e.p != t);
    if (e.m) misses++;
    else hits++;
    if (t) tbl[i] = min_i(tbl[i] + 1, CMAX);
    else   tbl[i] = (tbl[i] > 0) ? tbl[i] - 1 : 0;
    ghr      = ((ghr << 1) | int'(t)) % (1 << HIST_W);
    e.hits   = hits;
    e.misses = misses;
    return e;
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", name, act, exp, txn);
    end
  endfunction

  // Apply one cycle of stimulus and queue what the next edge must produce.
  task automatic drive(input bit r, input bit v, input int id, input bit t);
    exp_t e;
    reset     = r;
    valid     = v;
    branch_id = IDX_W'(id);
    outcome   = t;
    if (r) begin
      model_reset();
      e = '{ov: 1'b0, p: 1'b0, m: 1'b0, hits: 0, misses: 0};
    end else if (v) begin
      e = model_branch(id, t);
    end else begin
      e = '{ov: 1'b0, p: 1'b0, m: 1'b0, hits: hits, misses: misses};
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every cycle's result is compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d ov=%0d pred=%0d miss=%0d hits=%0d misses=%0d c4=%0d/%0d",
                 txn, out_valid, pred, miss, hit_count, miss_count, hit_count4, miss_count4);
        chk("out_valid",     int'(out_valid),   int'(e.ov));
        chk("pred",          int'(pred),        int'(e.p));
        chk("miss",          int'(miss),        int'(e.m));
        chk("hit_count",     int'(hit_count),   min_i(e.hits, CAP16));
        chk("miss_count",    int'(miss_count),  min_i(e.misses, CAP16));
        chk("c4_out_valid",  int'(out_valid4),  int'(e.ov));
        chk("c4_hit_count",  int'(hit_count4),  min_i(e.hits, CAP4));
        chk("c4_miss_count", int'(miss_count4), min_i(e.misses, CAP4));
      end
    end
  end

  initial begin
    int id;
    int bias;
    bit r;
    bit v;
    bit t;

    // Power-up state without any reset pulse.
    model_reset();
    #1;
    chk("t0_out_valid",  int'(out_valid),  0);
    chk("t0_pred",       int'(pred),       0);
    chk("t0_hit_count",  int'(hit_count),  0);
    chk("t0_miss_count", int'(miss_count), 0);

    // Same id taken twice: the first access misses, the second hits.
    drive(0, 1, 3, 1);
    drive(0, 1, 3, 1);
    drive(0, 0, 0, 0);

    // Saturate, one not-taken, then taken again (hysteresis).
    drive(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 1, 5, 1);
    drive(0, 1, 5, 0);
    drive(0, 1, 5, 1);

    // Alternating T,N on one id; 20 branches also saturates the 4-bit miss counter.
    drive(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive(0, 1, 0, (k % 2) == 0);

    // Reset that collides with a valid branch discards it.
    drive(0, 1, 2, 1);
    drive(0, 1, 2, 1);
    drive(1, 1, 2, 1);
    drive(0, 1, 2, 1);
    drive(0, 0, 0, 0);

    // Randomised traffic with per-id outcome bias, idle cycles and rare resets.
    for (int k = 0; k < 600; k++) begin
      r    = ($urandom_range(0, 59) == 0);
      v    = ($urandom_range(0, 3) != 0);
      id   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, DEPTH - 1));
      bias = id + 1;
      t    = ($urandom_range(0, DEPTH) < bias);
      drive(r, v, id, t);
    end

    drive(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
